// File: rtl/sram_like_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_axi_bridge
// Purpose  : SRAM-like data port to single-beat AXI3 read/write bridge,
//            one transaction outstanding. Optional macro: AXI_BRIDGE_ERR_EN.
// Revision : 1.0
// ============================================================================
module sram_like_axi_bridge (
    input  logic        clk,
    input  logic        rst,
    // SRAM-like side
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  select,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    // AXI read address
    output logic [3:0]  arid,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata_axi,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [3:0]  wid,
    output logic [31:0] wdata_axi,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
`ifdef AXI_BRIDGE_ERR_EN
    ,
    output logic        bus_err
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_AR  = 3'd1;
    localparam logic [2:0] RD_R   = 3'd2;
    localparam logic [2:0] WR_REQ = 3'd3;
    localparam logic [2:0] WR_B   = 3'd4;

    logic [2:0]  state_q,   state_d;
    logic [3:0]  select_q,  select_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        data_ok_q, data_ok_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;
    logic        bus_err_q, bus_err_d;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic [2:0]  w_size;

    // Transfer size decoded from the latched byte enables
    always_comb begin
        w_size = 3'd2;
        case (select_q)
            4'b1111:                            w_size = 3'd2;
            4'b0011, 4'b1100:                   w_size = 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = 3'd0;
            default:                            w_size = 3'd2;
        endcase
    end

    assign addr_ok   = rst && (state_q == IDLE) && req;
    assign data_ok   = data_ok_q;
    assign rdata     = rdata_q;

    assign arid      = 4'b0000;
    assign arlen     = 4'b0000;
    assign arsize    = w_size;
    assign arburst   = 2'b01;
    assign arlock    = 2'b00;
    assign arcache   = 4'b0000;
    assign arprot    = 3'b000;
    assign araddr    = addr_q;
    assign arvalid   = (state_q == RD_AR);
    assign rready    = (state_q == RD_R);

    assign awid      = 4'b0000;
    assign awlen     = 4'b0000;
    assign awsize    = w_size;
    assign awburst   = 2'b01;
    assign awlock    = 2'b00;
    assign awcache   = 4'b0000;
    assign awprot    = 3'b000;
    assign awaddr    = addr_q;
    assign awvalid   = (state_q == WR_REQ) && !aw_done_q;

    assign wid       = 4'b0000;
    assign wdata_axi = wdata_q;
    assign wstrb     = select_q;
    assign wlast     = 1'b1;
    assign wvalid    = (state_q == WR_REQ) && !w_done_q;
    assign bready    = (state_q == WR_B);

    assign w_aw_hs   = awvalid && awready;
    assign w_w_hs    = wvalid && wready;

    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        data_ok_d = 1'b0;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (req) begin
                    select_d = select;
                    addr_d   = addr;
                    wdata_d  = wdata;
                    state_d  = wr ? WR_REQ : RD_AR;
                end
            end
            RD_AR: begin
                if (arready) state_d = RD_R;
            end
            RD_R: begin
                if (rvalid) begin
                    rdata_d   = rdata_axi;
                    data_ok_d = 1'b1;
                    bus_err_d = (rresp != 2'b00);
                    state_d   = IDLE;
                end
            end
            WR_REQ: begin
                // Address and data channels complete independently, in any order
                if (w_aw_hs) aw_done_d = 1'b1;
                if (w_w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || w_aw_hs) && (w_done_q || w_w_hs)) begin
                    state_d   = WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_B: begin
                if (bvalid) begin
                    data_ok_d = 1'b1;
                    bus_err_d = (bresp != 2'b00);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            select_q  <= 4'b0000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            data_ok_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            data_ok_q <= data_ok_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef AXI_BRIDGE_ERR_EN
    assign bus_err = bus_err_q;
    logic unused_ok;
    assign unused_ok = &{1'b0, rid, rlast, bid};
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, rid, rlast, bid, rresp, bresp, bus_err_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_like_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_axi_bridge
// Purpose  : Directed checks of the SRAM-like to AXI3 bridge.
// Revision : 1.0
// ============================================================================
module tb_sram_like_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, wr = 1'b0;
    logic [3:0]  select = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic [31:0] araddr, awaddr, wdata_axi;
    logic        arvalid, rready, awvalid, wlast, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [3:0]  rid = 4'h0, bid = 4'h0;
    logic [31:0] rdata_axi = 32'h0;
    logic [1:0]  rresp = 2'b00, bresp = 2'b00;
`ifdef AXI_BRIDGE_ERR_EN
    logic        bus_err;
`endif

    int checks = 0;
    int errors = 0;
    int ok_count;

    sram_like_axi_bridge dut (
        .clk(clk), .rst(rst),
        .req(req), .wr(wr), .select(select), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef AXI_BRIDGE_ERR_EN
        , .bus_err(bus_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_addr_ok", {31'h0, addr_ok}, 32'd0);
        chk("rst_data_ok", {31'h0, data_ok}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_valids", {28'h0, arvalid, awvalid, wvalid, rready}, 32'h0);
        rst = 1'b1;
        tick();
        chk("idle_bready", {31'h0, bready}, 32'd0);

        // Read with zero-wait slave
        req = 1'b1; wr = 1'b0; select = 4'b1111; addr = 32'h1000_0004;
        #1;
        chk("rd_addr_ok", {31'h0, addr_ok}, 32'd1);
        tick();
        req = 1'b0;
        chk("rd_arvalid", {31'h0, arvalid}, 32'd1);
        chk("rd_araddr", araddr, 32'h1000_0004);
        chk("rd_arsize", {29'h0, arsize}, 32'd2);
        chk("rd_fixed", {arid, arlen, arburst, 22'h0}, {4'h0, 4'h0, 2'b01, 22'h0});
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rd_rready", {30'h0, arvalid, rready}, 32'd1);
        rvalid = 1'b1; rdata_axi = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0; rdata_axi = 32'h0;
        chk("rd_data_ok", {31'h0, data_ok}, 32'd1);
        chk("rd_rdata", rdata, 32'hDEAD_BEEF);
        tick();
        chk("rd_data_ok_pulse", {31'h0, data_ok}, 32'd0);
        chk("rd_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Write, wready three cycles after awready
        req = 1'b1; wr = 1'b1; select = 4'b0011; addr = 32'h2000_0002; wdata = 32'h0000_1234;
        #1;
        chk("wr_addr_ok", {31'h0, addr_ok}, 32'd1);
        tick();
        req = 1'b0;
        chk("wr_valids", {30'h0, awvalid, wvalid}, 32'd3);
        chk("wr_awsize", {29'h0, awsize}, 32'd1);
        chk("wr_wstrb", {28'h0, wstrb}, 32'h3);
        chk("wr_wdata", wdata_axi, 32'h0000_1234);
        chk("wr_awaddr", awaddr, 32'h2000_0002);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("wr_aw_drop", {29'h0, awvalid, wvalid, bready}, 32'b010);
        tick();
        chk("wr_w_hold", {29'h0, awvalid, wvalid, bready}, 32'b010);
        tick();
        chk("wr_w_hold2", {29'h0, awvalid, wvalid, bready}, 32'b010);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        chk("wr_bready", {29'h0, awvalid, wvalid, bready}, 32'b001);
        chk("wr_no_early_ok", {31'h0, data_ok}, 32'd0);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("wr_data_ok", {31'h0, data_ok}, 32'd1);
        chk("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
        tick();
        chk("wr_data_ok_pulse", {31'h0, data_ok}, 32'd0);

        // Byte write with req held high throughout
        ok_count = 0;
        req = 1'b1; wr = 1'b1; select = 4'b0100; addr = 32'h2000_0006; wdata = 32'h00AB_0000;
        #1;
        if (addr_ok) ok_count++;
        tick();
        if (addr_ok) ok_count++;
        chk("bw_awsize", {29'h0, awsize}, 32'd0);
        chk("bw_wstrb", {28'h0, wstrb}, 32'h4);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        if (addr_ok) ok_count++;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        req = 1'b0;
        #1;
        chk("bw_data_ok", {31'h0, data_ok}, 32'd1);
        chk("bw_addr_ok_once", ok_count, 32'd1);
        tick();

        // Back-to-back reads: second request accepted in the data_ok cycle
        req = 1'b1; wr = 1'b0; select = 4'b1111; addr = 32'h1000_0100;
        tick();
        req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata_axi = 32'h1111_2222;
        tick();
        rvalid = 1'b0;
        req = 1'b1; select = 4'b0101; addr = 32'h3000_0000;
        #1;
        chk("b2b_data_ok", {31'h0, data_ok}, 32'd1);
        chk("b2b_addr_ok", {31'h0, addr_ok}, 32'd1);
        tick();
        req = 1'b0;
        chk("b2b_arvalid", {31'h0, arvalid}, 32'd1);
        chk("b2b_araddr", araddr, 32'h3000_0000);
        chk("b2b_arsize_odd", {29'h0, arsize}, 32'd2);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata_axi = 32'h1234_5678;
        tick();
        rvalid = 1'b0;
        chk("b2b_rdata", rdata, 32'h1234_5678);
        tick();

        // Asynchronous reset while waiting in RD_R
        req = 1'b1; wr = 1'b0; select = 4'b1111; addr = 32'h1000_0200;
        tick();
        req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rr_in_rd_r", {31'h0, rready}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rr_async_rready", {31'h0, rready}, 32'd0);
        chk("rr_async_rdata", rdata, 32'h0);
        chk("rr_async_valids", {29'h0, arvalid, awvalid, wvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        req = 1'b1; wr = 1'b0; select = 4'b1000; addr = 32'h1000_0300;
        #1;
        chk("rr_idle_accept", {31'h0, addr_ok}, 32'd1);
        tick();
        req = 1'b0;
        chk("rr_arsize_byte", {29'h0, arsize}, 32'd0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata_axi = 32'hCAFE_F00D;
        tick();
        rvalid = 1'b0;
        chk("rr_after_data_ok", {31'h0, data_ok}, 32'd1);
        chk("rr_after_rdata", rdata, 32'hCAFE_F00D);
        tick();

`ifdef AXI_BRIDGE_ERR_EN
        // Error response flagged alongside data_ok
        req = 1'b1; wr = 1'b1; select = 4'b1111; addr = 32'h4000_0000;
        tick();
        req = 1'b0;
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        chk("err_bus_err", {30'h0, bus_err, data_ok}, 32'd3);
        tick();
        chk("err_bus_err_pulse", {31'h0, bus_err}, 32'd0);
        req = 1'b1;
        tick();
        req = 1'b0;
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("ok_bus_err", {30'h0, bus_err, data_ok}, 32'd1);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_like_axi_bridge.md
# sram_like_axi_bridge

Data-side bridge directly downstream of the memory-stage SRAM-like request shaper. It accepts one SRAM-like transaction (req/wr/select/addr/wdata) at a time, converts it into a single-beat AXI3 read or write, and returns addr_ok/data_ok/rdata to the shaper. Only one transaction is outstanding at a time; a new request is accepted only after the previous data_ok.

## Interface
- No parameters; AXI ID is fixed 4'b0000, len 4'b0000, burst 2'b01, cache/prot/lock 0.
- clk  in  1  system clock, all state on posedge
- rst  in  1  reset, asynchronous, active-low (`RstEnable` = 1'b0)
- req  in  1  SRAM-like request valid
- wr  in  1  1 = write, 0 = read
- select  in  4  byte enables
- addr  in  32  byte address
- wdata  in  32  write data
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  one-cycle completion pulse
- rdata  out  32  read data, valid with data_ok (read)
- arid/arlen/arsize/arburst/araddr/arvalid, arready: AXI3 read-address channel (araddr 32, arsize 3)
- rid/rdata_axi/rresp/rlast/rvalid, rready: read-data channel (rdata_axi 32, rresp 2)
- awid/awlen/awsize/awburst/awaddr/awvalid, awready: write-address channel
- wid/wdata_axi/wstrb/wlast/wvalid, wready: write-data channel (wstrb 4, wlast = 1)
- bid/bresp/bvalid, bready: write-response channel
- bus_err  out  1  only with AXI_BRIDGE_ERR_EN (see Configuration)

## Operation
- FSM states: IDLE, RD_AR, RD_R, WR_REQ, WR_B.
- IDLE: addr_ok = req (combinational). On req: latch wr/select/addr/wdata; go RD_AR (wr=0) or WR_REQ (wr=1).
- RD_AR: arvalid=1, araddr = latched addr. On arready -> RD_R.
- RD_R: rready=1. On rvalid: capture rdata_axi into rdata, pulse data_ok next cycle, -> IDLE.
- WR_REQ: awvalid and wvalid asserted on entry; each drops independently after its own handshake (aw_done/w_done flags). When both done (incl. same cycle) -> WR_B.
- WR_B: bready=1. On bvalid: pulse data_ok next cycle, -> IDLE.
- size from select: 4'b1111 -> 3'd2; 4'b0011/4'b1100 -> 3'd1; one-hot -> 3'd0; any other pattern -> 3'd2. wstrb = latched select; addr passed unmodified.
- rid/bid ignored; rlast not checked.
- addr_ok never asserted outside IDLE; req while busy is held off (upstream keeps req high).

## Timing
- Reset values: addr_ok=0, data_ok=0, rdata=0, all valid/ready=0, bus_err=0, state IDLE, flags cleared.
- Reset mid-transaction: immediate return to IDLE; pending AXI handshake abandoned (system-wide reset assumed).
- Read latency: req accepted cycle T; arvalid at T+1; with arready at T+1 and rvalid at T+2, data_ok/rdata at T+3.
- Write latency: awvalid/wvalid at T+1; both ready at T+1, bvalid at T+2 -> data_ok at T+3.
- data_ok exactly one cycle; rdata holds until next read completion.
- Earliest next accept: cycle of data_ok (state already IDLE).
- AXI valids never drop before handshake; address/data stable while valid.

## Configuration
- AXI_BRIDGE_ERR_EN defined: bus_err registered, pulses with data_ok when the captured rresp/bresp != 2'b00; data_ok still pulses, rdata still updated.
- Undefined: bus_err port absent, resp fields ignored.

## Test plan
- Read, 0-wait slave: req, wr=0, addr=32'h1000_0004 -> arvalid T+1, araddr=32'h1000_0004, arsize=2; rdata_axi=32'hDEAD_BEEF -> data_ok & rdata=32'hDEAD_BEEF at T+3.
- Write, wready 3 cycles after awready: select=4'b0011, wdata=32'h0000_1234 -> awsize=1, wstrb=4'b0011, bready only after both handshakes; single data_ok after bvalid.
- Byte write select=4'b0100 -> awsize=0, wstrb=4'b0100; req held high during transaction -> addr_ok only once.
- Back-to-back: second read req presented at data_ok cycle -> accepted same cycle, no bubble beyond FSM.
- rst low while in RD_R -> all outputs 0 asynchronously, state IDLE, following read completes normally.
- With AXI_BRIDGE_ERR_EN: bresp=2'b10 -> bus_err=1 with data_ok for one cycle; bresp=2'b00 -> bus_err=0.
